// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared FSM state, counter sizing and default timing for the pin debouncer.
package button_debouncer_pkg;
   typedef enum logic {IDLE, COUNT} state_e;
   localparam int CLK_HZ      = 12_000_000;
   localparam int DEBOUNCE_MS = 1;
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction
endpackage

// File: rtl/button_debouncer_sync_chain.sv
// sync_chain: plain shift-register synchroniser for one asynchronous pin.
module sync_chain #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= {STAGES{RESET_LEVEL}};
      else        sync_q <= {sync_q[STAGES-2:0], d};
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces one push-button level, emitting
// a clean level plus one-cycle rise/fall pulses.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_out,
   output logic rise,
   output logic fall
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("button_debouncer: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
   end
   logic          sync_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          btn_q, btn_d, rise_q, rise_d, fall_q, fall_d;
   logic          diff;
   sync_chain #(.STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (btn_in),
      .q    (sync_q)
   );
   assign diff = sync_q != btn_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      case (state_q)
         IDLE:
            if (!diff) cnt_d = '0;
            else if (DEBOUNCE_CYCLES == 1) btn_d = sync_q;
            else begin
               cnt_d   = CW'(1);
               state_d = COUNT;
            end
         COUNT:
            if (!diff || cnt_q == LAST) begin
               btn_d   = diff ? sync_q : btn_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
      rise_d = btn_d & ~btn_q;
      fall_d = ~btn_d & btn_q;
   end
   // pulses are registered alongside btn_q so they line up with the level change
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         btn_q   <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   assign btn_out = btn_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios plus randomized run against a run-length reference model.
module tb_button_debouncer;
   logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b1;
   logic out0, rise0, fall0, out1, rise1, fall1;
   int tests = 0, fails = 0;
   int dcy[2] = '{4, 1};
   bit m_out[2], m_rise[2], m_fall[2];
   int m_run[2];
   bit hist[$] = '{1'b0, 1'b0};
   bit s;

   button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_out(out0), .rise(rise0), .fall(fall0));
   button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_out(out1), .rise(rise1), .fall(fall1));

   always #5 clk = ~clk;

   // Reference: the synchronised level is btn_in delayed by two edges; the output
   // follows once that level has differed from it for D consecutive edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist = '{1'b0, 1'b0};
         for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
         end
      end else begin
         s = hist.pop_front();
         hist.push_back(btn_in);
         for (int i = 0; i < 2; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (s != m_out[i]) begin
               m_run[i]++;
               if (m_run[i] >= dcy[i]) begin
                  m_out[i] = s; m_run[i] = 0; m_rise[i] = s; m_fall[i] = !s;
               end
            end else m_run[i] = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic level);
      @(negedge clk);
      btn_in = level;
      rst_n  = 1'b0;
      step();
      rst_n  = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({out0, rise0, fall0, out1, rise1, fall1} !== 6'b0) begin
         fails++;
         $display("FAIL reset_immediate got %b want 000000", {out0, rise0, fall0, out1, rise1, fall1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== {k >= 6, k == 6, 1'b0}) begin
            fails++;
            $display("FAIL reset_release edge %0d got %b want %b", k, {out0, rise0, fall0}, {k >= 6, k == 6, 1'b0});
         end
      end
   endtask

   task automatic test_press_release();
      do_reset(1'b0);
      repeat (3) step();
      btn_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== {k >= 6, k == 6, 1'b0}) begin
            fails++;
            $display("FAIL press edge %0d got %b want %b", k, {out0, rise0, fall0}, {k >= 6, k == 6, 1'b0});
         end
      end
      btn_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== {k < 6, 1'b0, k == 6}) begin
            fails++;
            $display("FAIL release edge %0d got %b want %b", k, {out0, rise0, fall0}, {k < 6, 1'b0, k == 6});
         end
      end
   endtask

   task automatic test_bounce();
      do_reset(1'b0);
      repeat (3) step();
      for (int seg = 0; seg < 4; seg++) begin
         btn_in = (seg % 2 == 0);
         repeat ($urandom_range(1, 3)) begin
            step();
            tests++;
            if ({out0, rise0, fall0} !== 3'b000) begin
               fails++;
               $display("FAIL bounce_toggle seg %0d got %b want 000", seg, {out0, rise0, fall0});
            end
         end
      end
      btn_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== {k >= 6, k == 6, 1'b0}) begin
            fails++;
            $display("FAIL bounce_settle edge %0d got %b want %b", k, {out0, rise0, fall0}, {k >= 6, k == 6, 1'b0});
         end
      end
   endtask

   task automatic test_near_miss();
      do_reset(1'b0);
      repeat (3) step();
      btn_in = 1'b1;
      repeat (3) step();
      btn_in = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== 3'b000) begin
            fails++;
            $display("FAIL near_miss edge %0d got %b want 000", k, {out0, rise0, fall0});
         end
      end
      tests++;
      if (dut0.cnt_q !== 3'd0) begin
         fails++;
         $display("FAIL near_miss_cnt got %0d want 0", dut0.cnt_q);
      end
   endtask

   task automatic test_reset_midcount();
      do_reset(1'b0);
      repeat (3) step();
      btn_in = 1'b1;
      repeat (4) step();
      tests++;
      if (dut0.cnt_q !== 3'd2) begin
         fails++;
         $display("FAIL midcount_setup cnt got %0d want 2", dut0.cnt_q);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({out0, rise0, fall0, dut0.cnt_q} !== 6'b0) begin
         fails++;
         $display("FAIL midcount_reset got %b want 000000", {out0, rise0, fall0, dut0.cnt_q});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         tests++;
         if ({out0, rise0, fall0} !== {k >= 6, k == 6, 1'b0}) begin
            fails++;
            $display("FAIL midcount_release edge %0d got %b want %b", k, {out0, rise0, fall0}, {k >= 6, k == 6, 1'b0});
         end
      end
   endtask

   task automatic test_degenerate();
      do_reset(1'b0);
      repeat (3) step();
      btn_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         tests++;
         if ({out1, rise1, fall1} !== {k >= 3, k == 3, 1'b0}) begin
            fails++;
            $display("FAIL d1_press edge %0d got %b want %b", k, {out1, rise1, fall1}, {k >= 3, k == 3, 1'b0});
         end
      end
      btn_in = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         btn_in = 1'b1;
         tests++;
         if ({out1, rise1, fall1} !== {k != 3, k == 4, k == 3}) begin
            fails++;
            $display("FAIL d1_glitch edge %0d got %b want %b", k, {out1, rise1, fall1}, {k != 3, k == 4, k == 3});
         end
      end
   endtask

   task automatic test_random();
      do_reset(1'b0);
      for (int n = 0; n < 80; n++) begin
         btn_in = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 7)) begin
            step();
            tests++;
            if ({out0, rise0, fall0, out1, rise1, fall1} !==
                {m_out[0], m_rise[0], m_fall[0], m_out[1], m_rise[1], m_fall[1]}) begin
               fails++;
               $display("FAIL random got %b want %b", {out0, rise0, fall0, out1, rise1, fall1},
                        {m_out[0], m_rise[0], m_fall[0], m_out[1], m_rise[1], m_fall[1]});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_near_miss();
      test_reset_midcount();
      test_degenerate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions one raw, asynchronous push-button or switch level before it drives a combinational gate input, such as one leg of the two-input OR logic block.
- Synchronises the pin into the clock domain and filters contact bounce.
- Outputs a clean level plus single-cycle rise and fall pulses.
- One instance per physical input; the outputs feed downstream gate inputs directly.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range ≥2).
- DEBOUNCE_CYCLES, 12000, consecutive clock cycles the synchronised level must differ from btn_out before btn_out follows (≥1; 12000 = 1 ms at 12 MHz).
- RESET_LEVEL, 0, value loaded into btn_out and all synchroniser flops at reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- btn_in  input  1  raw pin level; asynchronous, may bounce.
- btn_out  output  1  debounced, synchronised level.
- rise  output  1  one-cycle pulse when btn_out goes 0→1.
- fall  output  1  one-cycle pulse when btn_out goes 1→0.

Behaviour:
- Reset (rst_n=0, immediate, no clock needed):
  - sync flops = RESET_LEVEL, btn_out = RESET_LEVEL.
  - counter = 0, state = IDLE, rise = 0, fall = 0.
- Release of rst_n is taken synchronously; the first active edge is the one after deassertion.
- Synchroniser: shift chain of SYNC_STAGES flops; sync_q is the last stage. No logic sits between stages.
- Counter width = clog2(DEBOUNCE_CYCLES+1). It is unsigned and never wraps; it is cleared before it can exceed DEBOUNCE_CYCLES-1.
- FSM, 2 states:
  - IDLE:
    - If sync_q == btn_out: stay, counter = 0.
    - If sync_q != btn_out and DEBOUNCE_CYCLES == 1: update btn_out on this edge, stay IDLE.
    - If sync_q != btn_out otherwise: counter = 1, go to COUNT.
  - COUNT:
    - If sync_q == btn_out (bounce back): counter = 0, go to IDLE, no output change.
    - If sync_q != btn_out and counter == DEBOUNCE_CYCLES-1: btn_out = sync_q, counter = 0, go to IDLE.
    - If sync_q != btn_out otherwise: counter += 1.
- Latency:
  - Take the edge that first samples a new stable btn_in level as edge 1.
  - btn_out changes at edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - Example: S=2, D=4 gives edge 6.
- Pulses:
  - rise/fall are registered and go high in exactly the cycle btn_out changes; they are low the following cycle.
  - rise and fall are never both 1.
  - No pulse is generated by reset or by reset release.
- Glitch rule: any sync_q excursion shorter than DEBOUNCE_CYCLES consecutive cycles produces no output change and no pulse.
- Reset mid-count: all state is discarded. After release, filtering restarts from a full DEBOUNCE_CYCLES even if btn_in is already stable.
- If btn_in is held at !RESET_LEVEL through reset release, btn_out follows after the normal latency, with one matching pulse.
- btn_in is never used outside the first synchroniser flop.

Decomposition:
- Shared package:
  - state enum {IDLE, COUNT}.
  - cnt_width() helper function.
  - Default timing constants CLK_HZ = 12_000_000 and DEBOUNCE_MS = 1.
- Sub-module: sync_chain (parameter STAGES, RESET_LEVEL; ports clk, rst_n, d, q), reusable for other pin inputs.
- Elaboration-time checks on illegal SYNC_STAGES/DEBOUNCE_CYCLES stop the build.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless stated.
- Reset: assert rst_n=0 with btn_in=1 and no clock -> btn_out=0, rise=0, fall=0 immediately; after release with btn_in held 1 -> btn_out=1 and rise=1 at edge 6, rise=0 at edge 7.
- Clean press/release: btn_in 0→1 held 20 cycles, then 1→0 -> btn_out rises at edge 6 with one rise pulse; falls 6 edges after release with one fall pulse.
- Bounce: btn_in toggles 1,0,1,0,1 each lasting 1–3 cycles, then holds 1 -> no output change during the toggling; btn_out=1 and a single rise pulse exactly 6 edges after the final transition.
- Near-miss: btn_in high for exactly 3 cycles, then low -> btn_out stays 0; no pulses; counter returns to 0.
- Reset mid-count: drop rst_n during COUNT with counter=2 -> all outputs 0 at once; after release with btn_in=1, full 6-edge latency again with one rise.
- Degenerate case, DEBOUNCE_CYCLES=1 -> btn_out follows a stable btn_in change at edge 3; a 1-cycle btn_in glitch passes as a 1-cycle btn_out pulse.
